// File: rtl/prog_lut.sv
// prog_lut: run-time programmable lookup table.
// The table has one synchronous write port, NUM_RD independent registered
// read channels, and a sweep-clear engine that writes INIT_VAL to every
// entry, one entry per cycle.
module prog_lut #(
  parameter int unsigned          ADDR_W   = 3,
  parameter int unsigned          DATA_W   = 4,
  parameter int unsigned          NUM_RD   = 2,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_err,
  input  logic                       clr_req,
  output logic                       busy,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // The sweep ends on the all-ones address (DEPTH-1), never on DEPTH.
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     wr_err_q, wr_err_d;
  logic                     wr_ok_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_valid_q;

  // Sweep FSM next state: IDLE starts a sweep on clr_req, CLEAR walks the counter to the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q;
        end
      end
      S_CLEAR: begin
        // The counter wraps to zero naturally after the last entry.
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Write arbitration: a write is accepted only in IDLE without a competing clear; otherwise it is flagged.
  always_comb begin
    if ((state_q == S_IDLE) && !clr_req) begin
      wr_ok_s  = wr_en;
      wr_err_d = 1'b0;
    end else begin
      wr_ok_s  = 1'b0;
      wr_err_d = wr_en;
    end
    busy_d = (state_d == S_CLEAR);
  end

  // Control registers: FSM state, sweep counter, busy and write-error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {ADDR_W{1'b0}};
      busy_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Table storage: reset loads every entry; the sweep writes one entry per cycle, else an accepted write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= INIT_VAL;
      end
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (wr_ok_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read channels: registered, and they see pre-edge contents so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_data_q[i*DATA_W +: DATA_W] <= mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
          rd_valid_q[i]                 <= 1'b1;
        end else begin
          rd_valid_q[i]                 <= 1'b0;
        end
      end
    end
  end

  assign wr_err   = wr_err_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_prog_lut.sv
// tb_prog_lut: directed, table-driven bench for prog_lut (8 x 4-bit, 2 read channels).
module tb_prog_lut;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_err;
  logic       clr_req;
  logic       busy;
  logic [1:0] rd_en;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [1:0] rd_valid;

  int n_checks;
  int n_fail;

  prog_lut #(
    .ADDR_W  (3),
    .DATA_W  (4),
    .NUM_RD  (2),
    .INIT_VAL(4'h0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_err  (wr_err),
    .clr_req (clr_req),
    .busy    (busy),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       clr_req;
    logic [1:0] rd_en;
    logic [5:0] rd_addr;
    logic [1:0] exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 4'h0;
    clr_req = 1'b0;
    rd_en   = 2'b00;
    rd_addr = 6'd0;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic we, input logic [2:0] wa, input logic [3:0] wd, input logic cr,
                     input logic [1:0] re, input logic [5:0] ra,
                     input logic [1:0] ev, input logic [7:0] ed, input logic eb, input logic ee);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.clr_req = cr;
    v.rd_en = re; v.rd_addr = ra;
    v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] prog [8];
    int         cnt;
    bit         done;

    n_checks = 0;
    n_fail   = 0;
    prog[0] = 4'h0; prog[1] = 4'hA; prog[2] = 4'hA; prog[3] = 4'h6;
    prog[4] = 4'h9; prog[5] = 4'h5; prog[6] = 4'h5; prog[7] = 4'hF;

    // Reset values read back on ch0 from every address.
    for (int a = 0; a < 8; a++)
      add(1'b0, 3'd0, 4'h0, 1'b0, 2'b01, {3'd0, 3'(a)}, 2'b01, 8'h00, 1'b0, 1'b0);
    // Program the table; read data holds.
    for (int a = 0; a < 8; a++)
      add(1'b1, 3'(a), prog[a], 1'b0, 2'b00, 6'd0, 2'b00, 8'h00, 1'b0, 1'b0);
    // Dual-channel read: ch0 addr 3, ch1 addr 7.
    add(1'b0, 3'd0, 4'h0, 1'b0, 2'b11, {3'd7, 3'd3}, 2'b11, 8'hF6, 1'b0, 1'b0);
    // Read-before-write on addr 4 (ch1), ch0 holds 6.
    add(1'b1, 3'd4, 4'h3, 1'b0, 2'b10, {3'd4, 3'd0}, 2'b10, 8'h96, 1'b0, 1'b0);
    // Both channels now see the new value.
    add(1'b0, 3'd0, 4'h0, 1'b0, 2'b11, {3'd4, 3'd4}, 2'b11, 8'h33, 1'b0, 1'b0);
    // No read: valid drops, data holds.
    add(1'b0, 3'd0, 4'h0, 1'b0, 2'b00, 6'd0, 2'b00, 8'h33, 1'b0, 1'b0);

    // Reset
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset wr_err", wr_err, 1'b0);
    chk("reset rd_valid", rd_valid, 2'b00);
    chk("reset rd_data", rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      wr_en   = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr;
      wr_data = vecs[i].wr_data;
      clr_req = vecs[i].clr_req;
      rd_en   = vecs[i].rd_en;
      rd_addr = vecs[i].rd_addr;
      tick();
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d wr_err", i), wr_err, vecs[i].exp_err);
    end
    idle_inputs();

    // Sweep: busy for exactly 8 edges, repeated clr_req ignored, read of an
    // unswept entry mid-sweep, and a write dropped while busy.
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      if (k == 0 || k == 2 || k == 7) clr_req = 1'b1;
      if (k == 3) begin
        rd_en   = 2'b01;
        rd_addr = {3'd0, 3'd7};
      end
      if (k == 4) begin
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 4'hC;
      end
      tick();
      chk($sformatf("sweep busy k%0d", k), busy, (k <= 7) ? 1'b1 : 1'b0);
      chk($sformatf("sweep wr_err k%0d", k), wr_err, (k == 4) ? 1'b1 : 1'b0);
      if (k == 3) chk("sweep read addr7 mid-sweep", rd_data, 8'h3F);
    end
    for (int a = 0; a < 8; a++) begin
      idle_inputs();
      rd_en   = 2'b01;
      rd_addr = {3'd0, 3'(a)};
      tick();
      chk($sformatf("after sweep addr%0d", a), rd_data[3:0], 4'h0);
      chk($sformatf("after sweep valid%0d", a), rd_valid, 2'b01);
    end

    // Write and clear on the same cycle: clear wins.
    idle_inputs();
    wr_en   = 1'b1;
    wr_addr = 3'd7;
    wr_data = 4'hB;
    clr_req = 1'b1;
    tick();
    chk("collide wr_err", wr_err, 1'b1);
    chk("collide busy", busy, 1'b1);
    idle_inputs();
    rd_en   = 2'b01;
    rd_addr = {3'd0, 3'd7};
    tick();
    chk("collide wr_err pulse width", wr_err, 1'b0);
    chk("collide addr7 not written", rd_data[3:0], 4'h0);
    idle_inputs();
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 20) begin
      if (!busy) done = 1'b1;
      else begin
        tick();
        cnt++;
      end
    end
    chk("collide sweep ends in time", done, 1'b1);

    // Reset in the middle of a sweep.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hA;
    tick();
    wr_addr = 3'd6; wr_data = 4'h5;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    rd_en   = 2'b01;
    rd_addr = {3'd0, 3'd6};
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 4'h1;
    tick();
    chk("midsweep pre-reset read addr6", rd_data[3:0], 4'h5);
    chk("midsweep pre-reset wr_err", wr_err, 1'b1);
    chk("midsweep pre-reset busy", busy, 1'b1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsweep reset busy", busy, 1'b0);
    chk("midsweep reset wr_err", wr_err, 1'b0);
    chk("midsweep reset rd_valid", rd_valid, 2'b00);
    chk("midsweep reset rd_data", rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd6;
    wr_data = 4'hD;
    tick();
    chk("post-reset busy", busy, 1'b0);
    chk("post-reset wr_err", wr_err, 1'b0);
    for (int a = 0; a < 8; a++) begin
      idle_inputs();
      rd_en   = 2'b11;
      rd_addr = {3'(a), 3'd6};
      tick();
      chk($sformatf("post-reset ch0 addr6 (pass %0d)", a), rd_data[3:0], 4'hD);
      chk($sformatf("post-reset ch1 addr%0d", a), rd_data[7:4], (a == 6) ? 4'hD : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
